// File: rtl/pipeline_seq_pkg.sv
// Shared FSM state type, stage limit and width helper for the pipeline stage sequencer.
package pipeline_seq_pkg;

  localparam int MAX_STAGES = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } seq_state_t;

  function automatic int stage_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_onehot_dec.sv
// One-hot decoder turning a stage index into the child start vector.
module seq_onehot_dec
  import pipeline_seq_pkg::*;
#(
  parameter int N     = 4,
  parameter int SEL_W = 2
) (
  input  logic             i_en,
  input  logic [SEL_W-1:0] i_sel,
  output logic [N-1:0]     o_onehot
);

  // Comparing against every bit position keeps non-power-of-two N free of out-of-range indexing.
  always_comb begin
    o_onehot = {N{1'b0}};
    for (int k = 0; k < N; k++) begin
      o_onehot[k] = i_en & (i_sel == SEL_W'(k));
    end
  end

endmodule

// File: rtl/pipeline_stage_sequencer.sv
// Sequences NUM_STAGES child pipelines in order for num_iters outer iterations.
// Optional SEQ_PERF_CNT_EN adds the saturating busy_cycles counter of RUN cycles.
module pipeline_stage_sequencer
  import pipeline_seq_pkg::*;
#(
  parameter int  NUM_STAGES = 4,
  parameter int  ITER_W     = 8,
  localparam int STAGE_W    = stage_width(NUM_STAGES)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ap_start,
  input  logic [ITER_W-1:0]     num_iters,
  output logic                  ap_idle,
  output logic                  ap_ready,
  output logic                  ap_done,
  output logic [NUM_STAGES-1:0] child_ap_start,
  input  logic [NUM_STAGES-1:0] child_ap_done,
  output logic [STAGE_W-1:0]    stage_idx,
  output logic [ITER_W-1:0]     iter_idx,
  output logic                  seq_err
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0]           busy_cycles
`endif
);

  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_STAGES - 1);

  if (NUM_STAGES < 1 || NUM_STAGES > MAX_STAGES) begin : g_bad_stages
    $error("NUM_STAGES out of range 1..MAX_STAGES");
  end

  seq_state_t            r_state;
  seq_state_t            w_state_nxt;
  logic [STAGE_W-1:0]    r_stage;
  logic [STAGE_W-1:0]    w_stage_nxt;
  logic [ITER_W-1:0]     r_iter;
  logic [ITER_W-1:0]     w_iter_nxt;
  logic [ITER_W-1:0]     w_iter_inc;
  logic [ITER_W-1:0]     r_count;
  logic [ITER_W-1:0]     w_count_nxt;
  logic                  w_accept;
  logic                  w_hit;
  logic                  w_stray;
  logic                  w_idle_nxt;
  logic                  w_fin_nxt;
  logic                  w_run_nxt;
  logic                  w_err_nxt;
  logic [NUM_STAGES-1:0] w_start_nxt;
  logic                  r_ap_idle;
  logic                  r_ap_done;
  logic                  r_ap_ready;
  logic                  r_seq_err;
  logic [NUM_STAGES-1:0] r_child_start;

  // The registered start vector is exactly the set of dones that may legally arrive.
  assign w_accept   = (r_state == IDLE) & ap_start;
  assign w_hit      = |(child_ap_done & r_child_start);
  assign w_stray    = |(child_ap_done & ~r_child_start);
  assign w_iter_inc = r_iter + ITER_W'(1);

  // Next-state and counter update logic.
  always_comb begin
    w_state_nxt = r_state;
    w_stage_nxt = r_stage;
    w_iter_nxt  = r_iter;
    w_count_nxt = r_count;
    case (r_state)
      IDLE: begin
        if (ap_start) begin
          w_count_nxt = num_iters;
          w_iter_nxt  = {ITER_W{1'b0}};
          w_stage_nxt = {STAGE_W{1'b0}};
          w_state_nxt = (num_iters == {ITER_W{1'b0}}) ? FIN : RUN;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      RUN: begin
        if (w_hit && (r_stage == LAST_STAGE)) begin
          w_iter_nxt  = w_iter_inc;
          w_stage_nxt = {STAGE_W{1'b0}};
          w_state_nxt = (w_iter_inc == r_count) ? FIN : RUN;
        end else if (w_hit) begin
          w_stage_nxt = r_stage + STAGE_W'(1);
        end else begin
          w_state_nxt = RUN;
        end
      end
      FIN:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_stage <= {STAGE_W{1'b0}};
      r_iter  <= {ITER_W{1'b0}};
      r_count <= {ITER_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_stage <= w_stage_nxt;
      r_iter  <= w_iter_nxt;
      r_count <= w_count_nxt;
    end
  end

  // Outputs are derived from the next state so their registers line up with the state register.
  always_comb begin
    w_idle_nxt = (w_state_nxt == IDLE);
    w_fin_nxt  = (w_state_nxt == FIN);
    w_run_nxt  = (w_state_nxt == RUN);
    w_err_nxt  = r_seq_err | w_stray;
  end

  seq_onehot_dec #(
    .N     (NUM_STAGES),
    .SEL_W (STAGE_W)
  ) u_dec (
    .i_en     (w_run_nxt),
    .i_sel    (w_stage_nxt),
    .o_onehot (w_start_nxt)
  );

  // Output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ap_idle     <= 1'b1;
      r_ap_done     <= 1'b0;
      r_ap_ready    <= 1'b0;
      r_seq_err     <= 1'b0;
      r_child_start <= {NUM_STAGES{1'b0}};
    end else begin
      r_ap_idle     <= w_idle_nxt;
      r_ap_done     <= w_fin_nxt;
      r_ap_ready    <= w_fin_nxt;
      r_seq_err     <= w_err_nxt;
      r_child_start <= w_start_nxt;
    end
  end

  assign ap_idle        = r_ap_idle;
  assign ap_done        = r_ap_done;
  assign ap_ready       = r_ap_ready;
  assign seq_err        = r_seq_err;
  assign child_ap_start = r_child_start;
  assign stage_idx      = r_stage;
  assign iter_idx       = r_iter;

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] r_busy;

  // Saturating count of RUN cycles, restarted on every accepted start.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_busy <= 32'd0;
    end else if (w_accept) begin
      r_busy <= 32'd0;
    end else if ((r_state == RUN) && (r_busy != 32'hFFFF_FFFF)) begin
      r_busy <= r_busy + 32'd1;
    end else begin
      r_busy <= r_busy;
    end
  end

  assign busy_cycles = r_busy;
`endif

endmodule

// File: tb/tb_pipeline_stage_sequencer.sv
// Randomized self-checking bench: expected timelines come from per-stage done delays chosen up front.
module tb_pipeline_stage_sequencer;

  localparam int S  = 4;
  localparam int W  = 8;
  localparam int SW = 2;

  logic         clock = 1'b0;
  logic         reset;
  logic         ap_start;
  logic [W-1:0] num_iters;
  logic         ap_idle;
  logic         ap_ready;
  logic         ap_done;
  logic [S-1:0] child_ap_start;
  logic [S-1:0] child_ap_done;
  logic [SW-1:0] stage_idx;
  logic [W-1:0] iter_idx;
  logic         seq_err;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0]  busy_cycles;
`endif

  int   n_checks = 0;
  int   n_errors = 0;
  logic exp_err;
  int   last_iter;
  int   run_cycles;

  pipeline_stage_sequencer #(.NUM_STAGES(S), .ITER_W(W)) dut (
    .clock          (clock),
    .reset          (reset),
    .ap_start       (ap_start),
    .num_iters      (num_iters),
    .ap_idle        (ap_idle),
    .ap_ready       (ap_ready),
    .ap_done        (ap_done),
    .child_ap_start (child_ap_start),
    .child_ap_done  (child_ap_done),
    .stage_idx      (stage_idx),
    .iter_idx       (iter_idx),
    .seq_err        (seq_err)
`ifdef SEQ_PERF_CNT_EN
    ,
    .busy_cycles    (busy_cycles)
`endif
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_cycle(input string tag, input logic e_idle, input logic e_fin,
                             input logic [S-1:0] e_start, input int e_stage, input int e_iter,
                             input bit chk_stage);
    check_eq({tag, ".ap_idle"}, ap_idle, e_idle);
    check_eq({tag, ".ap_done"}, ap_done, e_fin);
    check_eq({tag, ".ap_ready"}, ap_ready, e_fin);
    check_eq({tag, ".child_ap_start"}, child_ap_start, e_start);
    check_eq({tag, ".iter_idx"}, iter_idx, e_iter);
    check_eq({tag, ".seq_err"}, seq_err, exp_err);
    if (chk_stage) check_eq({tag, ".stage_idx"}, stage_idx, e_stage);
  endtask

  // Idle cycles, occasionally with a child done that nobody asked for.
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      check_cycle("idle", 1'b1, 1'b0, '0, 0, last_iter, 1'b0);
      ap_start = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        child_ap_done = S'(1) << $urandom_range(0, S - 1);
        exp_err = 1'b1;
      end else begin
        child_ap_done = '0;
      end
      step();
    end
    child_ap_done = '0;
  endtask

  // fixed_d < 0 picks a random 0..3 cycle done delay per stage; stray: 0 none, 1 random, 2 done[2] at stage 0.
  task automatic run_txn(input int n_it, input int fixed_d, input int abort_seg, input int stray);
    int d;
    int stage;
    logic [S-1:0] oh;
    run_cycles = 0;
    check_cycle("pre", 1'b1, 1'b0, '0, 0, last_iter, 1'b0);
    ap_start      = 1'b1;
    num_iters     = W'(n_it);
    child_ap_done = '0;
    step();
    ap_start  = 1'b0;
    num_iters = W'($urandom);
    for (int g = 0; g < n_it * S; g++) begin
      stage = g % S;
      d     = (fixed_d >= 0) ? fixed_d : int'($urandom_range(0, 3));
      oh    = S'(1) << stage;
      for (int k = 0; k <= d; k++) begin
        check_cycle("run", 1'b0, 1'b0, oh, stage, g / S, 1'b1);
        if (g == abort_seg) begin
          reset = 1'b1;
          child_ap_done = '0;
          step();
          reset     = 1'b0;
          exp_err   = 1'b0;
          last_iter = 0;
          check_cycle("rst", 1'b1, 1'b0, '0, 0, 0, 1'b1);
          return;
        end
        ap_start      = ($urandom_range(0, 3) == 0);
        child_ap_done = (k == d) ? oh : '0;
        if (k < d && stray == 1 && $urandom_range(0, 4) == 0) begin
          child_ap_done = S'(1) << ((stage + 1 + int'($urandom_range(0, S - 2))) % S);
          exp_err = 1'b1;
        end else if (k < d && stray == 2 && g == 0 && k == 0) begin
          child_ap_done = S'(1) << 2;
          exp_err = 1'b1;
        end
        run_cycles++;
        step();
      end
    end
    ap_start      = 1'b0;
    child_ap_done = '0;
    check_cycle("fin", 1'b0, 1'b1, '0, 0, n_it, 1'b0);
`ifdef SEQ_PERF_CNT_EN
    check_eq("fin.busy_cycles", busy_cycles, run_cycles);
`endif
    step();
    last_iter = n_it;
  endtask

  initial begin
    reset = 1'b1; ap_start = 1'b0; num_iters = '0; child_ap_done = '0;
    exp_err = 1'b0; last_iter = 0;
    step();
    step();
    check_cycle("reset", 1'b1, 1'b0, '0, 0, 0, 1'b1);
`ifdef SEQ_PERF_CNT_EN
    check_eq("reset.busy_cycles", busy_cycles, 0);
`endif
    reset = 1'b0;
    step();
    run_txn(2, 3, -1, 0);
    run_txn(0, 0, -1, 0);
    run_txn(3, 0, -1, 0);
    run_txn(2, 2, -1, 2);
    check_eq("sticky.seq_err", seq_err, 1'b1);
    run_txn(4, -1, 2 * S + 1, 0);
    run_txn(1, 4, -1, 0);
`ifdef SEQ_PERF_CNT_EN
    check_eq("busy_20", busy_cycles, 20);
`endif
    run_txn((1 << W) - 1, 0, -1, 0);
    for (int t = 0; t < 15; t++) begin
      idle_cycles($urandom_range(0, 2));
      run_txn($urandom_range(0, 5), -1, -1, 1);
    end
    idle_cycles(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
